// File: rtl/kse_dbg_req_arbiter.sv
// Round-robin debug request arbiter for the secure-enclave access path: one outstanding
// transaction, per-channel lock gating, response watchdog and tag-based stale-response filtering.
module kse_dbg_req_arbiter #(
  parameter int unsigned NumChannels   = 2,
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TagWidth      = 2,
  parameter int unsigned TimeoutCycles = 1024,
  parameter int unsigned ChanIdxW      = $clog2(NumChannels)
) (
  input  logic                                  i_clk,
  input  logic                                  i_ao_rst_n,
  input  logic [NumChannels-1:0]                i_chan_en,
  input  logic [NumChannels-1:0]                i_req_valid,
  output logic [NumChannels-1:0]                o_req_ready,
  input  logic [NumChannels-1:0][AddrWidth-1:0] i_req_addr,
  input  logic [NumChannels-1:0][DataWidth-1:0] i_req_wdata,
  input  logic [NumChannels-1:0]                i_req_write,
  output logic [NumChannels-1:0]                o_rsp_valid,
  input  logic [NumChannels-1:0]                i_rsp_ready,
  output logic [DataWidth-1:0]                  o_rsp_rdata,
  output logic                                  o_rsp_error,
  output logic                                  o_rsp_timeout,
  output logic                                  o_rsp_ignored,
  output logic                                  o_se_valid,
  input  logic                                  i_se_ready,
  output logic [AddrWidth-1:0]                  o_se_addr,
  output logic [DataWidth-1:0]                  o_se_wdata,
  output logic                                  o_se_write,
  output logic [ChanIdxW-1:0]                   o_se_chan,
  output logic [TagWidth-1:0]                   o_se_tag,
  input  logic                                  i_se_rsp_valid,
  input  logic [TagWidth-1:0]                   i_se_rsp_tag,
  input  logic [DataWidth-1:0]                  i_se_rsp_rdata,
  input  logic                                  i_se_rsp_error,
  output logic                                  o_busy
);

  localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP,
    RESP
  } state_e;

  state_e               state_q, state_d;
  logic [ChanIdxW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [TagWidth-1:0]  tag_q, tag_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [ChanIdxW-1:0]  chan_q, chan_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic                 write_q, write_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic                 error_q, error_d;
  logic                 timeout_q, timeout_d;
  logic                 ignored_q, ignored_d;

  logic                 grant_vld;
  logic [ChanIdxW-1:0]  grant_idx;
  int unsigned          cand;
  logic                 rsp_match;

  // First valid channel at or after rr_ptr, wrapping around.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NumChannels; i++) begin
      cand = (32'(rr_ptr_q) + i) % NumChannels;
      if (!grant_vld && i_req_valid[ChanIdxW'(cand)]) begin
        grant_vld = 1'b1;
        grant_idx = ChanIdxW'(cand);
      end
    end
  end

  assign rsp_match = (state_q == WAIT_RSP) && i_se_rsp_valid && (i_se_rsp_tag == tag_q);

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    tag_d     = tag_q;
    cnt_d     = cnt_q;
    chan_d    = chan_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    rdata_d   = rdata_q;
    error_d   = error_q;
    timeout_d = timeout_q;
    ignored_d = ignored_q;
    unique case (state_q)
      IDLE: begin
        if (grant_vld) begin
          chan_d   = grant_idx;
          addr_d   = i_req_addr[grant_idx];
          wdata_d  = i_req_wdata[grant_idx];
          write_d  = i_req_write[grant_idx];
          rr_ptr_d = ChanIdxW'((32'(grant_idx) + 1) % NumChannels);
          if (i_chan_en[grant_idx]) begin
            tag_d   = tag_q + TagWidth'(1);
            state_d = ISSUE;
          end else begin
            // Locked channel is answered locally without touching the enclave.
            rdata_d   = '0;
            error_d   = 1'b0;
            timeout_d = 1'b0;
            ignored_d = 1'b1;
            state_d   = RESP;
          end
        end
      end
      ISSUE: begin
        if (i_se_ready) begin
          cnt_d   = '0;
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        cnt_d = cnt_q + CntW'(1);
        if (rsp_match) begin
          rdata_d   = i_se_rsp_rdata;
          error_d   = i_se_rsp_error;
          timeout_d = 1'b0;
          ignored_d = 1'b0;
          state_d   = RESP;
        end else if ((TimeoutCycles != 0) && (cnt_q == CntMax)) begin
          rdata_d   = '0;
          error_d   = 1'b1;
          timeout_d = 1'b1;
          ignored_d = 1'b0;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (i_rsp_ready[chan_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_ao_rst_n) begin
    if (!i_ao_rst_n) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      tag_q     <= '0;
      cnt_q     <= '0;
      chan_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
      ignored_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      tag_q     <= tag_d;
      cnt_q     <= cnt_d;
      chan_q    <= chan_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      rdata_q   <= rdata_d;
      error_q   <= error_d;
      timeout_q <= timeout_d;
      ignored_q <= ignored_d;
    end
  end

  always_comb begin
    o_req_ready = '0;
    o_rsp_valid = '0;
    if (state_q == IDLE && grant_vld) begin
      o_req_ready[grant_idx] = 1'b1;
    end
    if (state_q == RESP) begin
      o_rsp_valid[chan_q] = 1'b1;
    end
  end

  assign o_rsp_rdata   = (state_q == RESP) ? rdata_q : '0;
  assign o_rsp_error   = (state_q == RESP) && error_q;
  assign o_rsp_timeout = (state_q == RESP) && timeout_q;
  assign o_rsp_ignored = (state_q == RESP) && ignored_q;
  assign o_se_valid    = (state_q == ISSUE);
  assign o_se_addr     = addr_q;
  assign o_se_wdata    = wdata_q;
  assign o_se_write    = write_q;
  assign o_se_chan     = chan_q;
  assign o_se_tag      = tag_q;
  assign o_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_kse_dbg_req_arbiter.sv
// Self-checking bench for kse_dbg_req_arbiter: directed scenarios followed by randomized
// transactions, all checked against a transaction-level reference model.
module tb_kse_dbg_req_arbiter;

  localparam int NCh = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TW  = 2;
  localparam int TO  = 16;

  logic                   clk = 1'b0;
  logic                   rstN;
  logic [NCh-1:0]         chanEn;
  logic [NCh-1:0]         reqValid;
  logic [NCh-1:0]         reqReady;
  logic [NCh-1:0][AW-1:0] reqAddr;
  logic [NCh-1:0][DW-1:0] reqWdata;
  logic [NCh-1:0]         reqWrite;
  logic [NCh-1:0]         rspValid;
  logic [NCh-1:0]         rspReady;
  logic [DW-1:0]          rspRdata;
  logic                   rspError, rspTimeout, rspIgnored;
  logic                   seValid, seReady;
  logic [AW-1:0]          seAddr;
  logic [DW-1:0]          seWdata;
  logic                   seWrite;
  logic [0:0]             seChan;
  logic [TW-1:0]          seTag;
  logic                   seRspValid;
  logic [TW-1:0]          seRspTag;
  logic [DW-1:0]          seRspRdata;
  logic                   seRspError;
  logic                   busy;

  kse_dbg_req_arbiter #(
    .NumChannels(NCh), .AddrWidth(AW), .DataWidth(DW), .TagWidth(TW), .TimeoutCycles(TO)
  ) dut (
    .i_clk(clk), .i_ao_rst_n(rstN), .i_chan_en(chanEn), .i_req_valid(reqValid),
    .o_req_ready(reqReady), .i_req_addr(reqAddr), .i_req_wdata(reqWdata),
    .i_req_write(reqWrite), .o_rsp_valid(rspValid), .i_rsp_ready(rspReady),
    .o_rsp_rdata(rspRdata), .o_rsp_error(rspError), .o_rsp_timeout(rspTimeout),
    .o_rsp_ignored(rspIgnored), .o_se_valid(seValid), .i_se_ready(seReady),
    .o_se_addr(seAddr), .o_se_wdata(seWdata), .o_se_write(seWrite), .o_se_chan(seChan),
    .o_se_tag(seTag), .i_se_rsp_valid(seRspValid), .i_se_rsp_tag(seRspTag),
    .i_se_rsp_rdata(seRspRdata), .i_se_rsp_error(seRspError), .o_busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transaction-level reference model state.
  int          rrPtr = 0;
  int          tagM  = 0;
  logic [31:0] expAddr  [NCh];
  logic [31:0] expWdata [NCh];
  logic        expWrite [NCh];

  task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic idleInputs();
    reqValid   = '0;
    seReady    = 1'b0;
    rspReady   = '0;
    seRspValid = 1'b0;
    seRspTag   = '0;
    seRspRdata = '0;
    seRspError = 1'b0;
  endtask

  // Request inputs for the grant cycle; the expected payload is remembered by the model.
  task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] en, input bit fixCh0);
    for (int c = 0; c < NCh; c++) begin
      expAddr[c]  = $urandom;
      expWdata[c] = $urandom;
      expWrite[c] = 1'($urandom);
      if (fixCh0 && c == 0) begin
        expAddr[c]  = 32'h100;
        expWrite[c] = 1'b0;
      end
      reqAddr[c]  = expAddr[c];
      reqWdata[c] = expWdata[c];
      reqWrite[c] = expWrite[c];
    end
    reqValid = valid;
    chanEn   = en;
  endtask

  // Garbage on the request side while busy: must neither grant nor disturb the in-flight one.
  task automatic scrambleInputs();
    reqValid = 2'($urandom);
    chanEn   = 2'($urandom);
    reqWrite = 2'($urandom);
    for (int c = 0; c < NCh; c++) begin
      reqAddr[c]  = $urandom;
      reqWdata[c] = $urandom;
    end
  endtask

  task automatic checkResetOutputs(input string pfx);
    checkOutput({pfx, "_req_ready"}, reqReady, 0);
    checkOutput({pfx, "_rsp_valid"}, rspValid, 0);
    checkOutput({pfx, "_rsp_rdata"}, rspRdata, 0);
    checkOutput({pfx, "_rsp_flags"}, {rspError, rspTimeout, rspIgnored}, 0);
    checkOutput({pfx, "_se_valid"}, seValid, 0);
    checkOutput({pfx, "_se_payload"}, {seAddr, seWrite}, 0);
    checkOutput({pfx, "_se_wdata"}, seWdata, 0);
    checkOutput({pfx, "_se_chan_tag"}, {seChan, seTag}, 0);
    checkOutput({pfx, "_busy"}, busy, 0);
  endtask

  // One complete transaction. rspDelay >= TO means no response before the watchdog fires.
  // resetAt >= 0 aborts with an async reset in that WAIT_RSP cycle.
  task automatic runTxn(input logic [1:0] valid, input logic [1:0] en, input int seDelay,
                        input int rspDelay, input logic [31:0] rdata, input logic err,
                        input int rdyDelay, input bit stale, input bit fixCh0, input int resetAt);
    int          ch;
    bit          locked;
    bit          matched;
    bit          done;
    logic [31:0] eRdata;
    logic        eErr, eTo, eIg;
    ch = -1;
    for (int i = 0; i < NCh; i++) begin
      if (ch < 0 && valid[(rrPtr + i) % NCh]) ch = (rrPtr + i) % NCh;
    end
    rrPtr   = (ch + 1) % NCh;
    locked  = !en[ch];
    matched = 1'b0;
    if (!locked) tagM = (tagM + 1) % (1 << TW);

    applyStimulus(valid, en, fixCh0);
    #1;
    checkOutput("grant_onehot", reqReady, 64'(1) << ch);
    checkOutput("busy_at_grant", busy, 0);
    @(negedge clk);

    if (!locked) begin
      for (int k = 0; k <= seDelay; k++) begin
        scrambleInputs();
        seReady = (k == seDelay);
        #1;
        checkOutput("se_valid", seValid, 1);
        checkOutput("se_addr", seAddr, expAddr[ch]);
        checkOutput("se_wdata", seWdata, expWdata[ch]);
        checkOutput("se_write", seWrite, expWrite[ch]);
        checkOutput("se_chan", seChan, ch);
        checkOutput("se_tag", seTag, tagM);
        checkOutput("no_grant_issue", reqReady, 0);
        @(negedge clk);
      end
      seReady = 1'b0;
      done = 1'b0;
      for (int w = 0; w < TO && !done; w++) begin
        scrambleInputs();
        seRspValid = 1'b0;
        if (w == resetAt) begin
          idleInputs();
          rstN = 1'b0;
          #1;
          checkResetOutputs("rst_mid_wait");
          @(negedge clk);
          rstN  = 1'b1;
          rrPtr = 0;
          tagM  = 0;
          #1;
          checkOutput("busy_after_rst", busy, 0);
          return;
        end
        if (w == rspDelay) begin
          seRspValid = 1'b1;
          seRspTag   = TW'(tagM);
          seRspRdata = rdata;
          seRspError = err;
          matched    = 1'b1;
          done       = 1'b1;
        end else if (stale && w == 0) begin
          seRspValid = 1'b1;
          seRspTag   = TW'((tagM + (1 << TW) - 1) % (1 << TW));
          seRspRdata = ~rdata;
          seRspError = 1'b1;
        end
        #1;
        checkOutput("wait_no_rsp", rspValid, 0);
        checkOutput("wait_no_se", seValid, 0);
        checkOutput("wait_busy", busy, 1);
        checkOutput("no_grant_wait", reqReady, 0);
        if (w == TO - 1) done = 1'b1;
        @(negedge clk);
      end
      seRspValid = 1'b0;
    end

    if (locked) begin
      eRdata = '0; eErr = 1'b0; eTo = 1'b0; eIg = 1'b1;
    end else if (matched) begin
      eRdata = rdata; eErr = err; eTo = 1'b0; eIg = 1'b0;
    end else begin
      eRdata = '0; eErr = 1'b1; eTo = 1'b1; eIg = 1'b0;
    end

    for (int r = 0; r <= rdyDelay; r++) begin
      scrambleInputs();
      rspReady   = (r == rdyDelay) ? 2'(1 << ch) : 2'(1 << (1 - ch));
      seRspValid = 1'b0;
      if (!locked && !matched && r == 0) begin
        seRspValid = 1'b1;
        seRspTag   = TW'(tagM);
        seRspRdata = $urandom | 32'h1;
        seRspError = 1'b0;
      end
      #1;
      checkOutput("rsp_valid", rspValid, 64'(1) << ch);
      checkOutput("rsp_rdata", rspRdata, eRdata);
      checkOutput("rsp_error", rspError, eErr);
      checkOutput("rsp_timeout", rspTimeout, eTo);
      checkOutput("rsp_ignored", rspIgnored, eIg);
      checkOutput("rsp_no_se", seValid, 0);
      checkOutput("no_grant_rsp", reqReady, 0);
      @(negedge clk);
    end
    idleInputs();
    #1;
    checkOutput("idle_after_rsp", {busy, rspValid}, 0);
  endtask

  initial begin
    rstN = 1'b1;
    chanEn = '0;
    reqAddr = '0;
    reqWdata = '0;
    reqWrite = '0;
    idleInputs();
    #1 rstN = 1'b0;
    @(negedge clk);
    #1;
    checkResetOutputs("reset");
    @(negedge clk);
    rstN = 1'b1;

    $display("[TB] round-robin fairness");
    for (int n = 0; n < 4; n++) runTxn(2'b11, 2'b11, 0, 0, $urandom, 1'b0, 0, 1'b0, 1'b0, -1);

    $display("[TB] locked channel");
    runTxn(2'b01, 2'b10, 0, 0, 32'h0, 1'b0, 0, 1'b0, 1'b1, -1);

    $display("[TB] timeout then stale late response");
    runTxn(2'b01, 2'b11, 0, TO + 4, 32'h0, 1'b0, 1, 1'b0, 1'b0, -1);
    runTxn(2'b01, 2'b11, 0, 2, 32'hCAFE0123, 1'b0, 0, 1'b1, 1'b0, -1);

    $display("[TB] response wins the expiry cycle");
    runTxn(2'b10, 2'b11, 0, TO - 1, 32'hDEADBEEF, 1'b0, 0, 1'b0, 1'b0, -1);

    $display("[TB] backpressure");
    runTxn(2'b11, 2'b11, 5, 1, 32'h5A5A1234, 1'b1, 3, 1'b1, 1'b0, -1);

    $display("[TB] reset mid WAIT_RSP");
    runTxn(2'b10, 2'b11, 0, 10, 32'h0, 1'b0, 0, 1'b0, 1'b0, 3);
    runTxn(2'b11, 2'b11, 0, 0, 32'h12345678, 1'b0, 0, 1'b0, 1'b0, -1);

    $display("[TB] randomized transactions");
    for (int n = 0; n < 40; n++) begin
      runTxn(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)), $urandom_range(0, 3),
             $urandom_range(0, TO + 3), $urandom, 1'($urandom), $urandom_range(0, 2),
             1'($urandom), 1'b0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
